// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: EX-stage ALU with base integer ops and iterative RV32M multiply/divide
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   flush                      abort in-flight op and drop any held result
//   in_valid/in_ready          operand handshake (src1, src2, alu_sel sampled at accept)
//   out_valid/out_ready        result handshake (alu_result, zero_flag held until consumed)
//   busy                       high while an M op iterates
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      alu_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] opb;
  logic [SHW:0] cnt;
  logic is_div, neg, neg_r, div0;
  logic [1:0] fn;
  logic accept, is_m, a_s, b_s, s1n, s2n;
  logic [SHW-1:0] sh;
  logic [XLEN-1:0] base_res, ma, mb, diff, quo, rem, q, r, m_res;
  logic [XLEN:0] mul_sum, trial;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
  logic ge;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready && !flush;
  assign is_m = alu_sel[4:3] == 2'b10;
  assign sh = src2[SHW-1:0];
  assign s1n = src1[XLEN-1];
  assign s2n = src2[XLEN-1];
  always_comb begin
    base_res = '0;
    case (alu_sel)
      5'd0: base_res = src1 + src2;
      5'd1: base_res = src1 - src2;
      5'd2: base_res = src1 << sh;
      5'd3: base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      5'd4: base_res = {{(XLEN-1){1'b0}}, src1 < src2};
      5'd5: base_res = src1 ^ src2;
      5'd6: base_res = src1 >> sh;
      5'd7: base_res = $signed(src1) >>> sh;
      5'd8: base_res = src1 | src2;
      5'd9: base_res = src1 & src2;
      default: base_res = '0;
    endcase
  end
  // Signedness per M op: DIV/REM (fn[0]=0) are s/s; MULH s*s, MULHSU s*u; the rest unsigned.
  assign a_s = alu_sel[2] ? !alu_sel[0] : (alu_sel[1:0] == 2'd1 || alu_sel[1:0] == 2'd2);
  assign b_s = alu_sel[2] ? !alu_sel[0] : (alu_sel[1:0] == 2'd1);
  assign ma = (a_s && s1n) ? -src1 : src1;
  assign mb = (b_s && s2n) ? -src2 : src2;
  // Multiply: acc = {partial high, remaining multiplier}; add then shift right.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};
  // Restoring divide: acc = {remainder, dividend/quotient}; shift in next dividend bit and trial-subtract.
  assign trial = acc[2*XLEN-1:XLEN-1];
  assign ge = trial >= {1'b0, opb};
  assign diff = trial[XLEN-1:0] - opb;
  assign div_nxt = ge ? {diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  assign acc_nxt = is_div ? div_nxt : mul_nxt;
  // Sign-fix is taken from the final step's output so the result registers on that same edge.
  assign prod = neg ? -acc_nxt : acc_nxt;
  assign q = acc_nxt[XLEN-1:0];
  assign r = acc_nxt[2*XLEN-1:XLEN];
  assign quo = div0 ? '1 : neg ? -q : q;
  assign rem = neg_r ? -r : r;
  assign m_res = is_div ? (fn[1] ? rem : quo) : (fn == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      busy <= 1'b0;
      alu_result <= '0;
      zero_flag <= 1'b1;
      acc <= '0;
      opb <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      fn <= '0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (accept) begin
      if (is_m) begin
        state <= BUSY;
        busy <= 1'b1;
        out_valid <= 1'b0;
        cnt <= (SHW+1)'(XLEN);
        acc <= {{XLEN{1'b0}}, ma};
        opb <= mb;
        is_div <= alu_sel[2];
        fn <= alu_sel[1:0];
        neg <= alu_sel[2] ? (a_s && (s1n ^ s2n)) : ((a_s && s1n) ^ (b_s && s2n));
        neg_r <= a_s && s1n;
        div0 <= src2 == '0;
      end else begin
        state <= DONE;
        out_valid <= 1'b1;
        alu_result <= base_res;
        zero_flag <= base_res == '0;
      end
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == 1) begin
        state <= DONE;
        busy <= 1'b0;
        out_valid <= 1'b1;
        alu_result <= m_res;
        zero_flag <= m_res == '0;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule
